// File: rtl/vespa_prio_pkg.sv
// vespa_prio_pkg
//   Shared types and constants for the priority-latch resolver.
//   - state_t      : resolver FSM states
//   - WIN_*        : result codes presented on res_win
//   - STUCK_MARGIN : extra clear cycles granted beyond CLR_CYC + SYNC_STAGES
//                    before a still-high flag is declared stuck
package vespa_prio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    SETTLE  = 3'd3,
    PRESENT = 3'd4,
    CLEAR   = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_CH0  = 2'b01;
  localparam logic [1:0] WIN_CH1  = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int unsigned STUCK_MARGIN = 4;

endpackage

// File: rtl/vespa_prio_sync.sv
// vespa_prio_sync
//   Single-bit flip-flop synchroniser, SYNC_STAGES deep (2..4).
//   Ports:
//     i_clk : clock
//     i_rst : synchronous active-high reset, clears every stage
//     i_d   : asynchronous input
//     o_q   : synchronised output (last stage)
module vespa_prio_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sh[SYNC_STAGES-1];

endmodule

// File: rtl/vespa_prio_resolver.sv
// vespa_prio_resolver
//   Consumer stage for the two-channel stepdown priority latch pair. Arms the
//   latches, synchronises their flags, resolves winner / tie / timeout, hands
//   the result over a valid/ready handshake, then clears and re-arms.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     en          : allows the FSM to leave IDLE; low aborts WAIT/SETTLE
//     flag0/flag1 : asynchronous latched flags from the upstream pair
//     state_arm   : upstream Tstate drive (1 = armed, 0 = cleared)
//     res_valid/res_ready/res_win : result handshake and code
//     busy        : high whenever the FSM is not in IDLE
//     stuck_err   : sticky, a flag failed to clear in time
//   Optional (macro VESPA_PRIO_STATS_EN):
//     stats_clr   : one-cycle pulse zeroing the counters
//     win0_cnt, win1_cnt, tie_cnt, tmo_cnt : saturating 16-bit result counts
module vespa_prio_resolver
  import vespa_prio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE_CYC  = 3,
  parameter int unsigned CLR_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flag0,
  input  logic        flag1,
  output logic        state_arm,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_win,
  output logic        busy,
  output logic        stuck_err
`ifdef VESPA_PRIO_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] win0_cnt,
  output logic [15:0] win1_cnt,
  output logic [15:0] tie_cnt,
  output logic [15:0] tmo_cnt
`endif
);

  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYC);
  localparam logic [3:0]  SET_LOAD  = 4'(SETTLE_CYC);
  localparam logic [7:0]  CLR_MIN   = 8'(CLR_CYC - 1);
  localparam logic [7:0]  STUCK_LIM = 8'(CLR_CYC + SYNC_STAGES + STUCK_MARGIN - 1);

  logic        w_s0;
  logic        w_s1;
  logic [1:0]  w_flags;
  logic [1:0]  w_acc_or;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_nxt;
  logic [3:0]  r_set_cnt;
  logic [3:0]  w_set_nxt;
  logic [7:0]  r_clr_cnt;
  logic [7:0]  w_clr_nxt;
  logic [1:0]  r_first;
  logic [1:0]  w_first_nxt;
  logic [1:0]  r_acc;
  logic [1:0]  w_acc_nxt;
  logic [1:0]  r_win;
  logic [1:0]  w_win_nxt;
  logic        r_stuck;
  logic        w_stuck_nxt;
  logic        r_arm;
  logic        r_valid;
  logic        r_busy;

  vespa_prio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (flag0),
    .o_q   (w_s0)
  );

  vespa_prio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (flag1),
    .o_q   (w_s1)
  );

  assign w_flags  = {w_s1, w_s0};
  // Include the current cycle so the final SETTLE cycle still counts as
  // part of the tie window.
  assign w_acc_or = r_acc | w_flags;

  always_comb begin
    w_next      = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    w_set_nxt   = r_set_cnt;
    w_clr_nxt   = r_clr_cnt;
    w_first_nxt = r_first;
    w_acc_nxt   = r_acc;
    w_win_nxt   = r_win;
    w_stuck_nxt = r_stuck;

    case (r_state)
      IDLE: begin
        // Also holds here after a stuck error until both flags read low.
        if (en && (w_flags == 2'b00)) begin
          w_next = ARM;
        end
      end

      ARM: begin
        w_tmo_nxt = TMO_LOAD;
        w_next    = WAIT;
      end

      WAIT: begin
        // A loaded value of 0 never decrements, which disables the timeout.
        if (r_tmo_cnt != '0) begin
          w_tmo_nxt = r_tmo_cnt - 16'd1;
        end
        if (!en) begin
          w_clr_nxt = '0;
          w_next    = CLEAR;
        end else if (w_flags != 2'b00) begin
          w_first_nxt = w_flags;
          w_acc_nxt   = w_flags;
          w_set_nxt   = SET_LOAD;
          w_next      = SETTLE;
        end else if (r_tmo_cnt == 16'd1) begin
          w_win_nxt = WIN_NONE;
          w_next    = PRESENT;
        end
      end

      SETTLE: begin
        w_acc_nxt = w_acc_or;
        if (!en) begin
          w_clr_nxt = '0;
          w_next    = CLEAR;
        end else if (r_set_cnt == '0) begin
          w_win_nxt = (w_acc_or == 2'b11) ? WIN_TIE : r_first;
          w_next    = PRESENT;
        end else begin
          w_set_nxt = r_set_cnt - 4'd1;
        end
      end

      PRESENT: begin
        if (res_ready) begin
          w_clr_nxt = '0;
          w_next    = CLEAR;
        end
      end

      CLEAR: begin
        if (r_clr_cnt != 8'hFF) begin
          w_clr_nxt = r_clr_cnt + 8'd1;
        end
        if ((w_flags == 2'b00) && (r_clr_cnt >= CLR_MIN)) begin
          w_next = en ? ARM : IDLE;
        end else if ((w_flags != 2'b00) && (r_clr_cnt >= STUCK_LIM)) begin
          w_stuck_nxt = 1'b1;
          w_next      = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so state_arm, which drives
  // the asynchronous upstream latches, is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tmo_cnt <= '0;
      r_set_cnt <= '0;
      r_clr_cnt <= '0;
      r_first   <= '0;
      r_acc     <= '0;
      r_win     <= WIN_NONE;
      r_stuck   <= 1'b0;
      r_arm     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tmo_cnt <= w_tmo_nxt;
      r_set_cnt <= w_set_nxt;
      r_clr_cnt <= w_clr_nxt;
      r_first   <= w_first_nxt;
      r_acc     <= w_acc_nxt;
      r_win     <= w_win_nxt;
      r_stuck   <= w_stuck_nxt;
      r_arm     <= (w_next == ARM) || (w_next == WAIT) ||
                   (w_next == SETTLE) || (w_next == PRESENT);
      r_valid   <= (w_next == PRESENT);
      r_busy    <= (w_next != IDLE);
    end
  end

  assign state_arm = r_arm;
  assign res_valid = r_valid;
  assign res_win   = r_win;
  assign busy      = r_busy;
  assign stuck_err = r_stuck;

`ifdef VESPA_PRIO_STATS_EN
  logic        w_accept;
  logic [15:0] r_cnt [4];

  assign w_accept = r_valid && res_ready;

  // Counter index equals the result code: 0 timeout, 1 ch0, 2 ch1, 3 tie.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_accept && (r_cnt[r_win] != 16'hFFFF)) begin
      r_cnt[r_win] <= r_cnt[r_win] + 16'd1;
    end
  end

  assign tmo_cnt  = r_cnt[0];
  assign win0_cnt = r_cnt[1];
  assign win1_cnt = r_cnt[2];
  assign tie_cnt  = r_cnt[3];
`endif

endmodule

// File: tb/tb_vespa_prio_resolver.sv
// tb_vespa_prio_resolver
//   Self-checking bench for vespa_prio_resolver. Expected results are queued
//   when flags are driven and compared when res_valid appears.
module tb_vespa_prio_resolver;
  import vespa_prio_pkg::*;

  localparam int SYNC    = 2;
  localparam int SETTLE  = 3;
  localparam int CLRC    = 2;
  localparam int TMO     = 20;
  localparam int LAT     = SYNC + 1 + SETTLE + 1;
  localparam int CLR_LOW = (CLRC > SYNC + 1) ? CLRC : SYNC + 1;
  localparam int STUCK_N = CLRC + SYNC + 4;

  typedef struct packed {
    logic [1:0] win;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flag0 = 1'b0;
  logic       flag1 = 1'b0;
  logic       res_ready = 1'b0;
  logic       state_arm;
  logic       res_valid;
  logic [1:0] res_win;
  logic       busy;
  logic       stuck_err;
`ifdef VESPA_PRIO_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] win0_cnt, win1_cnt, tie_cnt, tmo_cnt;
`endif

  int   cyc = 0;
  int   arm_cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  vespa_prio_resolver #(
    .SYNC_STAGES (SYNC),
    .SETTLE_CYC  (SETTLE),
    .CLR_CYC     (CLRC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flag0     (flag0),
    .flag1     (flag1),
    .state_arm (state_arm),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_win   (res_win),
    .busy      (busy),
    .stuck_err (stuck_err)
`ifdef VESPA_PRIO_STATS_EN
    ,
    .stats_clr (stats_clr),
    .win0_cnt  (win0_cnt),
    .win1_cnt  (win1_cnt),
    .tie_cnt   (tie_cnt),
    .tmo_cnt   (tmo_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_arm();
    for (int i = 0; i < 50; i++) begin
      if (state_arm === 1'b1) break;
      tick(1);
    end
    arm_cyc = cyc;
  endtask

  task automatic wait_valid(output int vc, output bit ok);
    ok = 1'b0;
    vc = -1;
    for (int i = 0; i < 80; i++) begin
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        vc = cyc;
        break;
      end
      tick(1);
    end
  endtask

  // Accept the result, release the upstream latches and count disarmed cycles.
  task automatic accept_clear(output int low);
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    flag0 = 1'b0;
    flag1 = 1'b0;
    low = 0;
    while (state_arm === 1'b0 && low < 100) begin
      low++;
      tick(1);
    end
    arm_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    tick(3);
    n_vec++;
    if ({state_arm, res_valid, res_win, busy, stuck_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want 000000",
               {state_arm, res_valid, res_win, busy, stuck_err});
    end
`ifdef VESPA_PRIO_STATS_EN
    n_vec++;
    if ({win0_cnt, win1_cnt, tie_cnt, tmo_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_stats: got %h, want 0", {win0_cnt, win1_cnt, tie_cnt, tmo_cnt});
    end
`endif
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_ch0_win();
    int vc, low;
    bit ok;
    exp_t e;
    en = 1'b1;
    wait_arm();
    tick(2);
    flag0 = 1'b1;
    sb.push_back('{win: WIN_CH0, cyc: cyc + LAT});
    wait_valid(vc, ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || vc != e.cyc) begin
      n_err++;
      $display("FAIL ch0_latency: got cycle %0d, want %0d", vc, e.cyc);
    end
    n_vec++;
    if (res_win !== e.win) begin
      n_err++;
      $display("FAIL ch0_win: got %b, want %b", res_win, e.win);
    end
    accept_clear(low);
    n_vec++;
    if (low != CLR_LOW) begin
      n_err++;
      $display("FAIL ch0_clear_low: got %0d cycles, want %0d", low, CLR_LOW);
    end
  endtask

  task automatic test_tie();
    int vc, low;
    bit ok;
    exp_t e;
    int gaps[2] = '{2, 5};
    for (int k = 0; k < 2; k++) begin
      flag1 = 1'b1;
      sb.push_back('{win: (gaps[k] <= SETTLE + 1) ? WIN_TIE : WIN_CH1, cyc: cyc + LAT});
      tick(gaps[k]);
      flag0 = 1'b1;
      wait_valid(vc, ok);
      e = sb.pop_front();
      n_vec++;
      if (!ok || vc != e.cyc || res_win !== e.win) begin
        n_err++;
        $display("FAIL tie_gap%0d: got cycle %0d win %b, want cycle %0d win %b",
                 gaps[k], vc, res_win, e.cyc, e.win);
      end
      accept_clear(low);
    end
  endtask

  task automatic test_timeout();
    int vc, low;
    bit ok;
    exp_t e;
    // No flags: timeout after TMO WAIT cycles.
    sb.push_back('{win: WIN_NONE, cyc: arm_cyc + 1 + TMO});
    wait_valid(vc, ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || vc != e.cyc || res_win !== e.win) begin
      n_err++;
      $display("FAIL timeout_plain: got cycle %0d win %b, want cycle %0d win %b",
               vc, res_win, e.cyc, e.win);
    end
    accept_clear(low);
    // Flag synchronised exactly on the last WAIT cycle beats the timeout.
    tick(TMO - 2);
    flag1 = 1'b1;
    sb.push_back('{win: WIN_CH1, cyc: cyc + LAT});
    wait_valid(vc, ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || vc != e.cyc || res_win !== e.win) begin
      n_err++;
      $display("FAIL timeout_flag_wins: got cycle %0d win %b, want cycle %0d win %b",
               vc, res_win, e.cyc, e.win);
    end
    accept_clear(low);
  endtask

  task automatic test_abort();
    tick(2);
    en = 1'b0;
    tick(1);
    n_vec++;
    if (state_arm !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_clear: got arm %b busy %b, want arm 0 busy 1", state_arm, busy);
    end
    tick(2);
    n_vec++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy %b valid %b, want 0 0", busy, res_valid);
    end
    en = 1'b1;
    wait_arm();
  endtask

  task automatic test_backpressure();
    int vc, low, bad;
    bit ok;
    exp_t e;
    flag0 = 1'b1;
    sb.push_back('{win: WIN_CH0, cyc: cyc + LAT});
    wait_valid(vc, ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || vc != e.cyc || res_win !== e.win) begin
      n_err++;
      $display("FAIL bp_result: got cycle %0d win %b, want cycle %0d win %b",
               vc, res_win, e.cyc, e.win);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (res_valid !== 1'b1 || res_win !== e.win || state_arm !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d unstable cycles, want 0", bad);
    end
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    n_vec++;
    if (res_valid !== 1'b0 || state_arm !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: got valid %b arm %b, want 0 0", res_valid, state_arm);
    end
    flag0 = 1'b0;
    low = 1;
    tick(1);
    while (state_arm === 1'b0 && low < 100) begin
      low++;
      tick(1);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (state_arm !== 1'b1 || res_valid !== 1'b0) bad++;
      tick(1);
    end
    n_vec++;
    if (low != CLR_LOW || bad != 0) begin
      n_err++;
      $display("FAIL bp_one_clear: got low %0d extra %0d, want low %0d extra 0",
               low, bad, CLR_LOW);
    end
  endtask

  task automatic test_stuck();
    int vc;
    bit ok;
    exp_t e;
    flag0 = 1'b1;
    sb.push_back('{win: WIN_CH0, cyc: cyc + LAT});
    wait_valid(vc, ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || res_win !== e.win) begin
      n_err++;
      $display("FAIL stuck_result: got win %b, want %b", res_win, e.win);
    end
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    tick(STUCK_N - 1);
    n_vec++;
    if (stuck_err !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_early: got %b, want 0", stuck_err);
    end
    tick(1);
    n_vec++;
    if (stuck_err !== 1'b1 || busy !== 1'b0 || state_arm !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_set: got err %b busy %b arm %b, want 1 0 0",
               stuck_err, busy, state_arm);
    end
    tick(5);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_hold_idle: got busy %b, want 0", busy);
    end
    flag0 = 1'b0;
    tick(6);
    n_vec++;
    if (stuck_err !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL stuck_sticky: got err %b busy %b, want 1 1", stuck_err, busy);
    end
    rst = 1'b1;
    tick(1);
    n_vec++;
    if (stuck_err !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_rst: got %b, want 0", stuck_err);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_present();
    int vc;
    bit ok;
    exp_t e;
    wait_arm();
    flag1 = 1'b1;
    sb.push_back('{win: WIN_CH1, cyc: cyc + LAT});
    wait_valid(vc, ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || vc != e.cyc || res_win !== e.win) begin
      n_err++;
      $display("FAIL rstp_result: got cycle %0d win %b, want cycle %0d win %b",
               vc, res_win, e.cyc, e.win);
    end
    rst = 1'b1;
    tick(1);
    n_vec++;
    if ({state_arm, res_valid, res_win, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL rstp_outputs: got %b, want 00000", {state_arm, res_valid, res_win, busy});
    end
    flag1 = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

`ifdef VESPA_PRIO_STATS_EN
  task automatic test_stats();
    int vc, low;
    bit ok;
    exp_t e;
    wait_arm();
    for (int k = 0; k < 4; k++) begin
      flag0 = 1'b1;
      flag1 = (k == 3);
      sb.push_back('{win: (k == 3) ? WIN_TIE : WIN_CH0, cyc: cyc + LAT});
      wait_valid(vc, ok);
      e = sb.pop_front();
      n_vec++;
      if (!ok || vc != e.cyc || res_win !== e.win) begin
        n_err++;
        $display("FAIL stats_run%0d: got cycle %0d win %b, want cycle %0d win %b",
                 k, vc, res_win, e.cyc, e.win);
      end
      accept_clear(low);
    end
    n_vec++;
    if (win0_cnt !== 16'd3 || tie_cnt !== 16'd1 || win1_cnt !== 16'd0 || tmo_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL stats_counts: got w0 %0d w1 %0d tie %0d tmo %0d, want 3 0 1 0",
               win0_cnt, win1_cnt, tie_cnt, tmo_cnt);
    end
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    n_vec++;
    if ({win0_cnt, win1_cnt, tie_cnt, tmo_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL stats_clr: got %h, want 0", {win0_cnt, win1_cnt, tie_cnt, tmo_cnt});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ch0_win();
    test_tie();
    test_timeout();
    test_abort();
    test_backpressure();
    test_stuck();
    test_reset_present();
`ifdef VESPA_PRIO_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
